// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the program counter and issues one request per cycle to instruction
// memory.  A returned word is passed straight through on InstrF; if the
// hazard unit stalls fetch in the cycle the word arrives, it is captured in a
// one-entry buffer and replayed from the HOLD state without a re-fetch.
//
// Ports
//   Clk, RstN            clock, asynchronous active-low reset
//   StallF               hazard-unit stall (1 = hold PC)
//   PCSrcD, PCBranchD    taken branch and its target, resolved in decode
//   JumpD, PCJumpD       jump and its target, resolved in decode
//   IMemReq, IMemAddr    fetch request valid / address (= PCF)
//   IMemReady, IMemRdata memory response, may arrive in the request cycle
//   PCF, PCPlus4F        current PC and PC + 4
//   InstrF               fetched instruction, 0 (NOP) when none available
//   IMissF               fetch waiting on memory
//   MissCount            saturating count of cycles with IMissF high
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             StallF,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic             JumpD,
  input  logic [31:0]      PCJumpD,
  output logic             IMemReq,
  output logic [31:0]      IMemAddr,
  input  logic             IMemReady,
  input  logic [31:0]      IMemRdata,
  output logic [31:0]      PCF,
  output logic [31:0]      PCPlus4F,
  output logic [31:0]      InstrF,
  output logic             IMissF,
  output logic [CNT_W-1:0] MissCount
);

  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL = RESET_PC & WORD_MASK;

  typedef enum logic {
    S_REQ,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ibuf_q, ibuf_d;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic              redirect;
  logic [31:0]       redir_tgt;
  logic [31:0]       pc_plus4;
  logic [31:0]       next_pc;

  // Next-PC selection: jump beats branch beats sequential.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    redirect  = JumpD | PCSrcD;
    redir_tgt = (JumpD ? PCJumpD : PCBranchD) & WORD_MASK;
    next_pc   = redirect ? redir_tgt : pc_plus4;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ibuf_d   = ibuf_q;
    IMemReq  = 1'b0;
    IMissF   = 1'b0;
    InstrF   = ibuf_q;

    unique case (state_q)
      S_REQ: begin
        IMemReq = 1'b1;
        IMissF  = ~IMemReady;
        InstrF  = IMemReady ? IMemRdata : '0;
        if (IMemReady) begin
          if (!StallF) begin
            pc_d = next_pc;
          end else begin
            ibuf_d  = IMemRdata;
            state_d = S_HOLD;
          end
        end else if (redirect && !StallF) begin
          // Abandon the outstanding request; memory ignores it and the
          // redirect target is presented on the next cycle.
          pc_d = redir_tgt;
        end
      end

      S_HOLD: begin
        if (!StallF) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC_AL;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      miss_cnt_q <= '0;
    end else if (IMissF && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign IMemAddr  = pc_q;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4;
  assign MissCount = miss_cnt_q;

endmodule
